// File: rtl/vend_ctrl_p.sv
// Vending machine controller: item selection, coin credit with saturation,
// vend with per-item stock tracking and change return.
module vend_ctrl_p #(
  parameter int N_ITEMS    = 4,
  parameter int ITEM_W     = 2,
  parameter int CREDIT_W   = 8,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5,
  parameter int VAL_A      = 5,
  parameter int VAL_B      = 10,
  parameter int VAL_C      = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         cancel,
  input  logic                         done_money,
  input  logic                         continue_buy,
  input  logic                         deno_5,
  input  logic                         deno_10,
  input  logic                         deno_20,
  input  logic [ITEM_W-1:0]            item_in,
  input  logic [N_ITEMS*CREDIT_W-1:0]  price_tbl,
  input  logic                         restock,
  output logic [2:0]                   state,
  output logic [CREDIT_W-1:0]          credit,
  output logic [CREDIT_W-1:0]          price,
  output logic                         out_stock,
  output logic                         vend_valid,
  output logic [ITEM_W-1:0]            vend_item,
  output logic                         change_valid,
  output logic [CREDIT_W-1:0]          change_amt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_RECEIVE = 3'd2,
    S_COMPARE = 3'd3,
    S_VEND    = 3'd4,
    S_RETURN  = 3'd5
  } state_e;

  localparam int SUM_W = CREDIT_W + 2;
  localparam logic [SUM_W-1:0]   COIN_A     = SUM_W'(VAL_A);
  localparam logic [SUM_W-1:0]   COIN_B     = SUM_W'(VAL_B);
  localparam logic [SUM_W-1:0]   COIN_C     = SUM_W'(VAL_C);
  localparam logic [SUM_W-1:0]   CREDIT_MAX = {2'b00, {CREDIT_W{1'b1}}};
  localparam logic [ITEM_W:0]    ITEMS_LIM  = (ITEM_W + 1)'(N_ITEMS);
  localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);
  localparam logic [STOCK_W-1:0] STOCK_ONE  = STOCK_W'(1);

  state_e               r_state;
  state_e               w_nextState;
  logic [CREDIT_W-1:0]  r_credit;
  logic [ITEM_W-1:0]    r_selItem;
  logic [STOCK_W-1:0]   r_stock [N_ITEMS];

  logic [CREDIT_W-1:0]  w_priceArr [N_ITEMS];
  logic                 w_itemValid;
  logic [ITEM_W-1:0]    w_selIdx;
  logic                 w_selBlocked;
  logic [ITEM_W-1:0]    w_priceIdx;
  logic [CREDIT_W-1:0]  w_price;
  logic [SUM_W-1:0]     w_coinSum;
  logic [SUM_W-1:0]     w_creditSum;
  logic                 w_overflow;
  logic [CREDIT_W-1:0]  w_creditSat;
  logic                 w_canVend;

  for (genvar g = 0; g < N_ITEMS; g++) begin : g_price
    assign w_priceArr[g] = price_tbl[g*CREDIT_W +: CREDIT_W];
  end

  // Out-of-range selections are steered to index 0 so lookups never read X.
  assign w_itemValid  = ({1'b0, item_in} < ITEMS_LIM);
  assign w_selIdx     = w_itemValid ? item_in : '0;
  assign w_selBlocked = !w_itemValid || (r_stock[w_selIdx] == '0);
  assign w_priceIdx   = (r_state == S_SELECT) ? w_selIdx : r_selItem;
  assign w_price      = w_priceArr[w_priceIdx];

  assign w_coinSum   = (deno_5  ? COIN_A : '0)
                     + (deno_10 ? COIN_B : '0)
                     + (deno_20 ? COIN_C : '0);
  assign w_creditSum = {2'b00, r_credit} + w_coinSum;
  assign w_overflow  = (w_creditSum > CREDIT_MAX);
  assign w_creditSat = w_overflow ? {CREDIT_W{1'b1}} : w_creditSum[CREDIT_W-1:0];
  assign w_canVend   = (r_credit >= w_price);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:    if (start) w_nextState = S_SELECT;
      S_SELECT: begin
        if (cancel)             w_nextState = S_IDLE;
        else if (!w_selBlocked) w_nextState = S_RECEIVE;
      end
      S_RECEIVE: begin
        if (cancel || w_overflow) w_nextState = S_RETURN;
        else if (done_money)      w_nextState = S_COMPARE;
      end
      S_COMPARE: w_nextState = w_canVend ? S_VEND : S_RECEIVE;
      S_VEND:    w_nextState = S_RETURN;
      S_RETURN:  w_nextState = continue_buy ? S_SELECT : S_IDLE;
      default:   w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_credit  <= '0;
      r_selItem <= '0;
      for (int i = 0; i < N_ITEMS; i++) r_stock[i] <= STOCK_INIT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (restock)
            for (int i = 0; i < N_ITEMS; i++) r_stock[i] <= STOCK_INIT;
        end
        S_SELECT:  if (!cancel && !w_selBlocked) r_selItem <= item_in;
        S_RECEIVE: r_credit <= w_creditSat;
        S_VEND: begin
          r_credit <= r_credit - w_price;
          if (r_stock[r_selItem] != '0)
            r_stock[r_selItem] <= r_stock[r_selItem] - STOCK_ONE;
        end
        S_RETURN:  r_credit <= '0;
        default:   ;
      endcase
    end
  end

  // Pulses are masked while reset is high so an interrupted vend never leaks out.
  always_comb begin
    state        = r_state;
    credit       = r_credit;
    price        = w_price;
    out_stock    = (r_state == S_SELECT) && w_selBlocked;
    vend_valid   = (r_state == S_VEND) && !reset;
    vend_item    = vend_valid ? r_selItem : '0;
    change_valid = (r_state == S_RETURN) && !reset;
    change_amt   = change_valid ? r_credit : '0;
  end

endmodule

// File: doc/vend_ctrl_p.md
VEND_CTRL_P -- requirements
Module: vend_ctrl_p

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter N_ITEMS, 4, number of selectable products.
REQ-002 The block SHALL have parameter ITEM_W, 2, item index width, equal to clog2(N_ITEMS).
REQ-003 The block SHALL have parameter CREDIT_W, 8, width of credit, price and change values.
REQ-004 The block SHALL have parameter STOCK_W, 4, width of each per-item stock counter.
REQ-005 The block SHALL have parameter INIT_STOCK, 5, stock loaded into every item on reset and restock.
REQ-006 The block SHALL have parameters VAL_A, VAL_B, VAL_C, defaults 5, 10, 20, the coin values credited for deno_5, deno_10 and deno_20.
Ports (name, direction, width, meaning):
REQ-007 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-008 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 The block SHALL have ports start, cancel, done_money and continue_buy, each input, 1, level-sampled control.
REQ-010 The block SHALL have ports deno_5, deno_10 and deno_20, each input, 1, one-cycle coin-accept pulses.
REQ-011 The block SHALL have port item_in, input, ITEM_W, product selection.
REQ-012 The block SHALL have port price_tbl, input, N_ITEMS*CREDIT_W, flattened price table; item i occupies bits [i*CREDIT_W +: CREDIT_W].
REQ-013 The block SHALL have port restock, input, 1, reload all stock counters to INIT_STOCK.
REQ-014 The block SHALL have outputs state (3), credit (CREDIT_W), price (CREDIT_W) and out_stock (1).
REQ-015 The block SHALL have outputs vend_valid (1), vend_item (ITEM_W), change_valid (1) and change_amt (CREDIT_W).

Function
REQ-016 The state encoding SHALL be IDLE=0, SELECT=1, RECEIVE_MONEY=2, COMPARE=3, VEND=4, RETURN_CHANGE=5; codes 6-7 SHALL go to IDLE on the next cycle.
REQ-017 In IDLE: start -> SELECT; otherwise stay; restock is honoured only in IDLE and takes effect in one cycle.
REQ-018 In SELECT: cancel -> IDLE (highest priority); item_in >= N_ITEMS or zero stock -> stay, with out_stock=1; otherwise latch item_in into sel_item -> RECEIVE_MONEY.
REQ-019 price SHALL be combinational: price_tbl entry for item_in in SELECT, and for sel_item in all other states.
REQ-020 In RECEIVE_MONEY the block SHALL add the sum of all asserted coin pulses in the same cycle to credit; simultaneous pulses all count.
REQ-021 Credit addition SHALL saturate at 2^CREDIT_W-1; saturation sets the overflow condition and forces -> RETURN_CHANGE (full refund).
REQ-022 RECEIVE_MONEY priority SHALL be cancel -> RETURN_CHANGE, then overflow -> RETURN_CHANGE, then done_money -> COMPARE, else stay; a coin arriving with cancel or done_money is still credited.
REQ-023 In COMPARE: credit >= price -> VEND; otherwise -> RECEIVE_MONEY with credit retained.
REQ-024 In VEND, for exactly one cycle: vend_valid=1 and vend_item=sel_item, stock[sel_item] is decremented by 1 and credit is reduced by price; then -> RETURN_CHANGE.
REQ-025 In RETURN_CHANGE, for exactly one cycle: change_valid=1 and change_amt=credit (zero allowed), and credit is cleared to 0.
REQ-026 RETURN_CHANGE exit: continue_buy -> SELECT, else -> IDLE.
REQ-027 Stock counters SHALL never underflow; a decrement at 0 is impossible by REQ-018 and SHALL be blocked regardless.
REQ-028 Arithmetic SHALL be unsigned at CREDIT_W bits; the coin sum is formed at CREDIT_W+2 bits before the saturation check.
REQ-029 vend_valid and change_valid SHALL never be asserted in the same cycle.

Reset
REQ-030 While reset=1 at a rising clk edge: state=IDLE, credit=0, sel_item=0, all stock=INIT_STOCK, and vend_valid, change_valid, change_amt, vend_item and out_stock all 0.
REQ-031 Reset SHALL override every other input in any state, including mid-VEND; no vend_valid or change_valid pulse is emitted in the reset cycle or the cycle after.

Verification
REQ-032 Scenario, exact pay: price[1]=15; start, item 1, deno_5 then deno_10, done_money -> COMPARE, then VEND with vend_item=1 and stock[1] 5->4, then change_valid with change_amt=0.
REQ-033 Scenario, overpay and insufficient: price[2]=25, deno_10 then done_money -> COMPARE -> RECEIVE_MONEY with credit=10; then deno_20 and done_money -> VEND, then change_amt=5.
REQ-034 Scenario, cancel refund: credit 30, cancel asserted together with deno_5 -> RETURN_CHANGE with change_amt=35, no vend_valid.
REQ-035 Scenario, out of stock: 5 vends of item 0, then selecting item 0 -> SELECT held with out_stock=1; restock in IDLE -> stock[0]=5.
REQ-036 Scenario, saturation: CREDIT_W=5, coins totalling 35 -> credit=31, then RETURN_CHANGE with change_amt=31.
REQ-037 Scenario, reset mid-VEND: reset asserted in the VEND cycle -> next state IDLE, credit 0, stock restored to INIT_STOCK, no pulses.
